// File: rtl/main_pkg.sv
`default_nettype none
// ============================================================================
// main_pkg : shared frame timing constants, state encoding, RAM defaults
// Revision : 1.0
// ============================================================================
package main_pkg;

    localparam int FRAME_CYCLES = 150;
    localparam int CMD_DEPTH    = 32;
    localparam int FC_W         = 8;
    localparam int IDX_W        = 5;

    // Frame-counter landmarks: first data bit, first sclk-high slot,
    // end of the 16 data bits, chip-select release, last cycle.
    localparam logic [FC_W-1:0] c_fc_bit_first  = 8'd4;
    localparam logic [FC_W-1:0] c_fc_sclk_first = 8'd8;
    localparam logic [FC_W-1:0] c_fc_bits_end   = 8'd132;
    localparam logic [FC_W-1:0] c_fc_cs_high    = 8'd136;
    localparam logic [FC_W-1:0] c_fc_last       = 8'd149;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Power-up command: register-read of register k.
    function automatic logic [15:0] ram_default(input logic [IDX_W-1:0] k);
        return {2'b11, 6'(k), 8'h00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_frame_engine.sv
`default_nettype none
// ============================================================================
// spi_frame_engine : frame counter, SPI pin generation, MISO shift register
// Revision : 1.0
// ============================================================================
module spi_frame_engine #(
    parameter int FRAME_CYCLES = main_pkg::FRAME_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        active,
    input  logic [15:0] cmd,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_b,
    output logic        mosi,
    output logic        frame_end,
    output logic [15:0] miso_word
);
    import main_pkg::*;

    localparam logic [FC_W-1:0] c_last_fc = FC_W'(FRAME_CYCLES - 1);

    logic [FC_W-1:0] r_fc;
    logic [15:0]     r_cmd;
    logic [15:0]     r_shift;
    logic [6:0]      w_rel;
    logic            w_in_bits;

    // w_rel[6:3] is the bit number, w_rel[2:0] the slot within the bit.
    assign w_rel     = 7'(r_fc - c_fc_bit_first);
    assign w_in_bits = active && (r_fc >= c_fc_bit_first) && (r_fc < c_fc_bits_end);

    assign frame_end = active && (r_fc == c_last_fc);
    assign cs_b      = !(active && (r_fc < c_fc_cs_high));
    assign sclk      = w_in_bits && w_rel[2];
    assign mosi      = w_in_bits && r_cmd[~w_rel[6:3]];
    assign miso_word = r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc    <= '0;
            r_cmd   <= '0;
            r_shift <= '0;
        end else if (clr) begin
            r_fc    <= '0;
            r_cmd   <= '0;
            r_shift <= '0;
        end else begin
            r_fc <= (active && !frame_end) ? r_fc + 1'b1 : '0;
            // Command is frozen for the frame so RAM writes land on the next one.
            if (active && (r_fc == '0)) begin
                r_cmd <= cmd;
            end
            if (w_in_bits && (w_rel[2:0] == 3'd4)) begin
                r_shift <= {r_shift[14:0], miso};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/main.sv
`default_nettype none
// ============================================================================
// main : SPI command sequencer with command RAM and host endpoints
// Revision : 1.0
// ============================================================================
module main #(
    parameter int FRAME_CYCLES = main_pkg::FRAME_CYCLES,
    parameter int CMD_DEPTH    = main_pkg::CMD_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ep00wirein,
    input  logic [31:0] ep01wirein,
    input  logic [31:0] ep02wirein,
    input  logic [31:0] ep03wirein,
    input  logic [31:0] ep04wirein,
    input  logic [31:0] ep05wirein,
    input  logic [31:0] ep40trigin,
    input  logic [31:0] ep41trigin,
    output logic [31:0] ep22wireout,
    output logic [31:0] ep24wireout,
    output logic        sclk,
    output logic        cs_b,
    output logic        mosi,
    input  logic        miso
);
    import main_pkg::*;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_last_idx;
    logic [IDX_W-1:0] w_index_next;
    logic [15:0]      r_frames;
    logic [15:0]      r_ram [CMD_DEPTH];
    logic [15:0]      w_miso_word;
    logic [31:0]      r_ep24;
    logic             r_stop_pending;
    logic             w_soft, w_start, w_stop, w_one_shot, w_wr;
    logic             w_active, w_frame_end, w_at_last;
    logic             w_unused;

    assign w_soft     = ep00wirein[0];
    assign w_one_shot = ep01wirein[0];
    assign w_wr       = ep40trigin[0];
    assign w_start    = ep41trigin[0];
    assign w_stop     = ep41trigin[2];
    assign w_unused   = ^{ep00wirein[31:1], ep01wirein[31:1], ep02wirein[31:5],
                          ep03wirein[31:16], ep04wirein, ep05wirein[31:5],
                          ep40trigin[31:1], ep41trigin[31:3], ep41trigin[1]};

    assign w_active     = (r_state == ST_RUN);
    assign w_at_last    = (r_index == r_last_idx);
    assign w_index_next = w_at_last ? '0 : r_index + 1'b1;

    assign ep22wireout = {r_frames, 3'b000, r_index, 7'b0000000, w_active};
    assign ep24wireout = r_ep24;

    spi_frame_engine #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_engine (
        .clk       (clk),
        .rst       (reset),
        .clr       (w_soft),
        .active    (w_active),
        .cmd       (r_ram[r_index]),
        .miso      (miso),
        .sclk      (sclk),
        .cs_b      (cs_b),
        .mosi      (mosi),
        .frame_end (w_frame_end),
        .miso_word (w_miso_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (w_soft) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stop wins over start; a running frame always finishes before IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start && !w_stop) w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_end && (r_stop_pending || w_stop || (w_one_shot && w_at_last)))
                         w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index        <= '0;
            r_last_idx     <= '0;
            r_frames       <= '0;
            r_ep24         <= '0;
            r_stop_pending <= 1'b0;
        end else if (w_soft) begin
            r_index        <= '0;
            r_last_idx     <= '0;
            r_frames       <= '0;
            r_ep24         <= '0;
            r_stop_pending <= 1'b0;
        end else if (!w_active) begin
            r_stop_pending <= 1'b0;
            if (w_state_next == ST_RUN) begin
                r_index    <= '0;
                r_last_idx <= ep05wirein[IDX_W-1:0];
            end
        end else begin
            if (w_stop) begin
                r_stop_pending <= 1'b1;
            end
            if (w_frame_end) begin
                r_ep24   <= {11'b0, r_index, w_miso_word};
                r_frames <= r_frames + 1'b1;
                r_index  <= w_index_next;
                // Pass length is re-sampled only when a new pass begins.
                if (w_at_last) begin
                    r_last_idx <= ep05wirein[IDX_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CMD_DEPTH; k++) begin
                r_ram[k[IDX_W-1:0]] <= ram_default(k[IDX_W-1:0]);
            end
        end else if (w_soft) begin
            for (int k = 0; k < CMD_DEPTH; k++) begin
                r_ram[k[IDX_W-1:0]] <= ram_default(k[IDX_W-1:0]);
            end
        end else if (w_wr) begin
            r_ram[ep02wirein[IDX_W-1:0]] <= ep03wirein[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main.sv
`default_nettype none
// ============================================================================
// tb_main : randomized bench for main against a frame-level behavioural model
// Revision : 1.0
// ============================================================================
module tb_main;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ep00, ep01, ep02, ep03, ep04, ep05, ep40, ep41;
    logic [31:0] ep22, ep24;
    logic        sclk, cs_b, mosi;
    logic        miso = 1'b0;

    main dut (
        .clk(clk), .reset(reset),
        .ep00wirein(ep00), .ep01wirein(ep01), .ep02wirein(ep02), .ep03wirein(ep03),
        .ep04wirein(ep04), .ep05wirein(ep05), .ep40trigin(ep40), .ep41trigin(ep41),
        .ep22wireout(ep22), .ep24wireout(ep24),
        .sclk(sclk), .cs_b(cs_b), .mosi(mosi), .miso(miso)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run;
    int          m_fc, m_idx, m_last, m_frames;
    bit          m_stop_req;
    logic [15:0] m_ram [32];
    logic [15:0] m_cmd, m_word;
    logic [31:0] m_ep24;

    task automatic model_reset();
        m_run = 0; m_fc = 0; m_idx = 0; m_last = 0; m_frames = 0;
        m_stop_req = 0; m_cmd = '0; m_word = '0; m_ep24 = '0;
        for (int k = 0; k < 32; k++) m_ram[k] = 16'(32'hC000 | (k << 8));
    endtask

    // Advance one clock using the inputs the DUT is about to sample.
    task automatic model_advance();
        bit wrapped;
        if (ep00[0]) begin
            model_reset();
            return;
        end
        if (m_run) begin
            if (m_fc == 0) m_cmd = m_ram[m_idx];
            if (m_fc >= 8 && m_fc <= 128 && (m_fc - 8) % 8 == 0) m_word = {m_word[14:0], miso};
            if (ep41[2]) m_stop_req = 1;
            if (m_fc == 149) begin
                wrapped  = (m_idx == m_last);
                m_ep24   = {11'b0, 5'(m_idx), m_word};
                m_frames = (m_frames + 1) % 65536;
                m_idx    = wrapped ? 0 : m_idx + 1;
                if (wrapped) m_last = int'(ep05[4:0]);
                if (m_stop_req || (ep01[0] && wrapped)) begin
                    m_run = 0;
                    m_stop_req = 0;
                end
                m_fc = 0;
            end else begin
                m_fc++;
            end
        end else begin
            m_stop_req = 0;
            if (ep41[0] && !ep41[2]) begin
                m_run = 1; m_fc = 0; m_idx = 0; m_last = int'(ep05[4:0]);
            end
        end
        if (ep40[0]) m_ram[ep02[4:0]] = ep03[15:0];
    endtask

    // ---------------- observation of shifted words ----------------
    logic [15:0] obs_q[$];
    logic [15:0] obs_cur = '0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1;
    int          cs_low_cnt = 0;

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic e_cs, e_sclk, e_mosi;
        int   bi;
        @(negedge clk);
        if (reset) model_reset();
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
        if (m_run) begin
            e_cs = (m_fc >= 136);
            if (m_fc >= 4 && m_fc < 132) begin
                bi     = (m_fc - 4) / 8;
                e_mosi = m_cmd[15 - bi];
                e_sclk = ((m_fc - 4) % 8) >= 4;
            end
        end
        chk("pins{cs_b,sclk,mosi}", {29'b0, cs_b, sclk, mosi}, {29'b0, e_cs, e_sclk, e_mosi});
        chk("ep22", ep22, {16'(m_frames), 3'b0, 5'(m_idx), 7'b0, m_run});
        chk("ep24", ep24, m_ep24);

        if (!cs_b) cs_low_cnt++;
        if (sclk && !prev_sclk && !cs_b) obs_cur = {obs_cur[14:0], mosi};
        if (cs_b && !prev_cs) obs_q.push_back(obs_cur);
        prev_sclk = sclk;
        prev_cs   = cs_b;

        if (!reset) model_advance();
    end

    // ---------------- MISO driver ----------------
    bit          miso_pat_mode = 0;
    logic [15:0] miso_pat = 16'hA5A5;
    initial forever begin
        @(posedge clk);
        #1;
        if (miso_pat_mode) begin
            if (m_run && m_fc >= 4 && m_fc < 132) miso = miso_pat[15 - (m_fc - 4) / 8];
            else miso = 1'b0;
        end else begin
            miso = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        bit          one_shot;
        logic [4:0]  last_n;

        reset = 1'b1;
        ep00 = '0; ep01 = '0; ep02 = '0; ep03 = '0; ep04 = '0; ep05 = '0; ep40 = '0; ep41 = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_ep22", ep22, 32'h0);
        chk("reset_ep24", ep24, 32'h0);
        chk("reset_pins", {29'b0, cs_b, sclk, mosi}, 32'h4);

        // Full 32-command pass with wrap to index 0.
        obs_q.delete();
        ep05 = 32'd31;
        ep41 = 32'h1; step(); ep41 = '0;
        repeat (4800) step();
        chk("s1_frames", 32'(ep22[31:16]), 32'd32);
        chk("s1_wrap_index", 32'(ep22[12:8]), 32'd0);
        chk("s1_running", 32'(ep22[0]), 32'd1);
        chk("s1_word0", 32'(obs_q[0]), 32'h0000C000);
        chk("s1_word31", 32'(obs_q[31]), 32'h0000DF00);
        chk("s1_ep24_index", 32'(ep24[20:16]), 32'd31);

        // Stop at fc 60 of the fourth frame after the wrap.
        repeat (510) step();
        ep41 = 32'h4; step(); ep41 = '0;
        repeat (100) step();
        chk("s3_frames", 32'(ep22[31:16]), 32'd36);
        chk("s3_running", 32'(ep22[0]), 32'd0);
        chk("s3_cs_b", 32'(cs_b), 32'd1);

        // Soft reset from IDLE, then one-shot single frame with MISO pattern.
        ep00 = 32'h1; step(); ep00 = '0; step();
        chk("soft_ep22", ep22, 32'h0);
        miso_pat_mode = 1;
        ep01 = 32'h1; ep05 = 32'h0;
        ep41 = 32'h1; step(); ep41 = '0;
        repeat (155) step();
        chk("s2_ep24", ep24, 32'h0000A5A5);
        chk("s2_frames", 32'(ep22[31:16]), 32'd1);
        chk("s2_running", 32'(ep22[0]), 32'd0);
        miso_pat_mode = 0;

        // RAM write then a 0..5 cycling run.
        ep01 = '0; ep02 = 32'd2; ep03 = 32'h1234;
        ep40 = 32'h1; step(); ep40 = '0;
        ep05 = 32'd5;
        obs_q.delete();
        ep41 = 32'h1; step(); ep41 = '0;
        repeat (2100) begin
            step();
            chk("s4_index_le_5", 32'(ep22[12:8] <= 5'd5), 32'd1);
        end
        chk("s5_word0", 32'(obs_q[0]), 32'h0000C000);
        chk("s5_word1", 32'(obs_q[1]), 32'h0000C100);
        chk("s5_word2", 32'(obs_q[2]), 32'h00001234);
        chk("s4_word6", 32'(obs_q[6]), 32'h0000C000);
        chk("s5_word8", 32'(obs_q[8]), 32'h00001234);
        ep41 = 32'h4; step(); ep41 = '0;
        repeat (200) step();
        chk("s4_stopped", 32'(ep22[0]), 32'd0);

        // Soft reset mid-frame.
        ep41 = 32'h1; step(); ep41 = '0;
        repeat (70) step();
        ep00 = 32'h1; step(); ep00 = '0;
        chk("s6_pins", {29'b0, cs_b, sclk, mosi}, 32'h4);
        chk("s6_ep22", ep22, 32'h0);
        chk("s6_ep24", ep24, 32'h0);

        // Simultaneous start and stop from IDLE.
        cs_low_cnt = 0;
        ep41 = 32'h5; step(); ep41 = '0;
        repeat (300) step();
        chk("s6_no_cs_activity", 32'(cs_low_cnt), 32'd0);
        chk("s6_idle_ep22", ep22, 32'h0);

        // Asynchronous reset mid-frame releases cs_b immediately.
        ep41 = 32'h1; step(); ep41 = '0;
        repeat (80) step();
        reset = 1'b1;
        #1;
        chk("areset_cs_b", 32'(cs_b), 32'd1);
        chk("areset_ep22", ep22, 32'h0);
        repeat (3) step();
        reset = 1'b0;
        step();

        // Randomized traffic.
        one_shot = 0;
        last_n   = 5'd3;
        repeat (8000) begin
            r = $urandom(); ep00 = {r[31:1], 1'($urandom_range(0, 4999) == 0)};
            if ($urandom_range(0, 999) == 0) one_shot = ~one_shot;
            r = $urandom(); ep01 = {r[31:1], one_shot};
            ep02 = $urandom(); ep03 = $urandom(); ep04 = $urandom();
            if ($urandom_range(0, 399) == 0) last_n = 5'($urandom_range(0, 7));
            r = $urandom(); ep05 = {r[31:5], last_n};
            r = $urandom(); ep40 = {r[31:1], 1'($urandom_range(0, 49) == 0)};
            r = $urandom();
            ep41 = {r[31:3], 1'($urandom_range(0, 599) == 0), r[1], 1'($urandom_range(0, 299) == 0)};
            step();
        end
        ep00 = '0; ep40 = '0; ep41 = '0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
